// File: rtl/noc_outport_switch.sv
// noc_outport_switch: registered N-to-1 output-port switch for the NoC router.
// Arbitrates among NIN input channels, holds a wormhole lock from head to tail
// so packets never interleave, and drives one registered valid/ready output.
// Optional feature macro: OSW_ROUND_ROBIN_EN selects round-robin arbitration;
// when undefined the lowest-index eligible input wins (fixed priority).
module noc_outport_switch #(
    parameter int NIN = 6,
    parameter int DW  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NIN*DW-1:0] in_data,
    input  logic [NIN-1:0]    in_valid,
    output logic [NIN-1:0]    in_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIN-1:0]    grant,
    output logic              locked
);
    localparam int         IW      = $clog2(NIN);
    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b01;

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t          state, state_next;
    logic [IW-1:0]   owner, owner_next;
    logic [NIN-1:0]  eligible;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [DW-1:0]   win_flit;
    logic [1:0]      win_type;
    logic            space;
    logic            accept;

    assign space    = !out_valid | out_ready;
    assign locked   = (state == ST_LOCKED);
    assign win_flit = in_data[int'(win_idx)*DW +: DW];
    assign win_type = win_flit[DW-1:DW-2];
    // Nothing is taken while reset is held, even though the slot looks free.
    assign accept   = rst_n & en & space & win_found;

    // Unlocked: any valid head/single may compete; locked: only the owner may send.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NIN; i++) begin
            if (locked)
                eligible[i] = in_valid[i] & (int'(owner) == i);
            else
                eligible[i] = in_valid[i] & in_data[i*DW + DW - 1];
        end
    end

`ifdef OSW_ROUND_ROBIN_EN
    logic [IW-1:0] ptr;

    // Round-robin search starting at ptr, wrapping NIN-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NIN; k++) begin
            if (!win_found && eligible[(int'(ptr) + k) % NIN]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr) + k) % NIN);
            end
        end
    end

    // Pointer moves just past the winner of every head or single accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (accept && win_type[1])
            ptr <= (int'(win_idx) == NIN - 1) ? '0 : win_idx + 1'b1;
    end
`else
    // Fixed priority: scanning downward leaves the lowest eligible index as winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NIN - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
            end
        end
    end
`endif

    // Handshake and ownership outputs decoded from the winner and the lock owner.
    always_comb begin
        in_ready = '0;
        grant    = '0;
        for (int i = 0; i < NIN; i++) begin
            in_ready[i] = accept & (int'(win_idx) == i);
            grant[i]    = locked & (int'(owner) == i);
        end
    end

    // Lock state and owner register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_UNLOCKED;
            owner <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    // Head locks to the winner, tail from the owner releases; singles leave the lock alone.
    always_comb begin
        state_next = state;
        owner_next = owner;
        if (accept) begin
            unique case (state)
                ST_UNLOCKED: begin
                    if (win_type == FT_HEAD) begin
                        state_next = ST_LOCKED;
                        owner_next = win_idx;
                    end
                end
                ST_LOCKED: begin
                    if (win_type == FT_TAIL)
                        state_next = ST_UNLOCKED;
                end
            endcase
        end
    end

    // Output register: load on accept, retire on out_ready, data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= win_flit;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/noc_outport_switch.md
# noc_outport_switch

Registered, parametrised N-to-1 output-port switch for the NoC router, the successor to the fixed six-input flit mux. It arbitrates among NIN input channels carrying DW-bit flits, holds a wormhole lock from head to tail flit so packets never interleave, and drives one output channel through a single output register with valid/ready flow control. One instance sits at each router output port, after the route-compute stage.

## Interface
- NIN, 6: number of input channels, 2..16
- DW, 40: flit width; bits [DW-1:DW-2] are flit type: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head+tail)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  port enable; low blocks all new input transfers
- in_data  input  NIN*DW  channel i flit on [i*DW +: DW]
- in_valid  input  NIN  channel i flit present
- in_ready  output  NIN  channel i flit accepted this cycle when in_valid[i] & in_ready[i]
- out_data  output  DW  registered flit
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- grant  output  NIN  one-hot owner while locked, else 0
- locked  output  1  wormhole lock held

## Operation
- Slot free: space = !out_valid | out_ready.
- Unlocked: eligible inputs are valid with type head or single. Arbiter picks one winner w; in_ready[w] = en & space; all others 0. Body/tail on an unlocked port is a protocol error: not eligible, in_ready held 0.
- Locked to owner o: only o eligible regardless of type; in_ready[o] = en & space; all others 0.
- On accepted transfer from w: out_data <= flit, out_valid <= 1. Type head: locked <= 1, owner <= w. Type tail (while locked): locked <= 0. Single: lock unchanged (stays 0).
- No accept and out_ready: out_valid <= 0; out_data holds last value (never tri-stated, never X after reset).
- en low: no accepts; out register still drains; lock and owner retained.
- in_ready is combinational from in_valid, flit type, en, out_valid, out_ready, lock state; no input combinationally depends on in_ready.
- States: UNLOCKED, LOCKED(o). UNLOCKED -> LOCKED(w) on head accept; LOCKED -> UNLOCKED on tail accept from o; all other cases stay.

## Timing
- Reset (async assert, sync-safe release): out_valid 0, out_data 0, locked 0, owner 0, grant 0, arbiter pointer 0.
- Latency: input accept at cycle T -> out_valid/out_data at T+1.
- Throughput: one flit per cycle when out_ready held high.
- Packet boundary: tail accepted at T, new head from any input may be accepted at T+1 (no bubble).
- Reset mid-packet: lock dropped, partial packet discarded from switch state; out_valid 0 immediately.
- Simultaneous out_ready and accept: register replaced, out_valid stays 1.

## Configuration
- OSW_ROUND_ROBIN_EN defined: round-robin; priority search starts at pointer p, wrapping NIN-1 -> 0; on each head or single accept from w, p <= (w+1) mod NIN.
- Not defined: fixed priority, lowest index wins; pointer logic absent.
- Lock behaviour identical in both.

## Test plan
- Reset: hold rst_n low with all in_valid high -> out_valid 0, out_data 0, in_ready 0, locked 0.
- Single flits, NIN=6, inputs 0,2,5 valid continuously with type 2'b11, out_ready 1 -> with round-robin, output order 0,2,5,0,2,... one per cycle; without, input 0 every cycle.
- Wormhole: input 1 sends head, body, body, tail while input 3 valid with head -> output is input 1's four flits contiguous, grant=6'b000010, locked 1 until tail; input 3 head accepted the cycle after tail.
- Backpressure: out_ready 0 for 3 cycles during a packet -> out_data held stable, in_ready[owner] 0 while out_valid 1, no flit lost or duplicated.
- en low mid-packet for 2 cycles -> no accepts, locked stays 1, transfer resumes on en high.
- Protocol error: unlocked port, input 4 presents body flit 2'b00 -> in_ready[4] stays 0, out_valid never set by it.
